// File: rtl/a1339_angle_unwrapper_pkg.sv
// a1339_angle_unwrapper_pkg: shared widths, turn constants and per-channel state for the angle unwrapper
// Contents: ANGLE_BITS/HALF_TURN/FULL_TURN, angle_raw_t, angle_abs_t, chan_state_t
package a1339_angle_unwrapper_pkg;
   localparam int ANGLE_BITS = 12;
   localparam int HALF_TURN  = 2048;
   localparam int FULL_TURN  = 4096;
   typedef logic [ANGLE_BITS-1:0] angle_raw_t;
   typedef logic signed [31:0] angle_abs_t;
   typedef struct packed {
      logic       initialised;
      angle_raw_t prev_raw;
      angle_abs_t rev;
      angle_abs_t absolute;
      angle_abs_t offset;
      angle_abs_t snapshot;
   } chan_state_t;
endpackage

// File: rtl/a1339_angle_unwrapper_if.sv
// a1339_angle_unwrapper_if: raw sample beat from the SPI sampling engine
// Signals: sample_valid, sample_channel[CH_W], sample_angle[12], sample_error
// Modports: master drives a beat, slave consumes it (no ready, every valid beat is taken)
interface a1339_angle_unwrapper_if #(parameter int CH_W = 3);
   import a1339_angle_unwrapper_pkg::*;
   logic            sample_valid;
   logic [CH_W-1:0] sample_channel;
   angle_raw_t      sample_angle;
   logic            sample_error;
   modport master(output sample_valid, sample_channel, sample_angle, sample_error);
   modport slave(input sample_valid, sample_channel, sample_angle, sample_error);
endinterface

// File: rtl/a1339_angle_unwrapper_channel.sv
// a1339_angle_unwrapper_channel: multi-turn unwrap, offset, velocity and error count for one channel
// Inputs:  clock, reset (async, active-high), update, error, zero, tick, raw[12]
// Outputs: absolute, offset, relative, revolution, velocity (signed 32), error_count[16]
module a1339_angle_unwrapper_channel
   import a1339_angle_unwrapper_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        update,
   input  logic        error,
   input  logic        zero,
   input  logic        tick,
   input  angle_raw_t  raw,
   output angle_abs_t  absolute,
   output angle_abs_t  offset,
   output angle_abs_t  relative,
   output angle_abs_t  revolution,
   output angle_abs_t  velocity,
   output logic [15:0] error_count
);
   chan_state_t       st;
   logic signed [12:0] delta;
   angle_abs_t        rev_n;
   angle_abs_t        abs_n;
   logic              init_n;

   assign absolute   = st.absolute;
   assign offset     = st.offset;
   assign revolution = st.rev;

   // A jump of more than half a turn between samples is taken as a crossing of the 0/4095 seam.
   always_comb begin
      delta  = $signed({1'b0, raw}) - $signed({1'b0, st.prev_raw});
      rev_n  = !(update && st.initialised) ? st.rev
             : int'(delta) >= HALF_TURN ? st.rev - 1
             : int'(delta) < -HALF_TURN ? st.rev + 1
             : st.rev;
      abs_n  = update ? rev_n * FULL_TURN + angle_abs_t'(raw) : st.absolute;
      init_n = st.initialised | update;
   end

   // zero and tick act on the post-update absolute so a coinciding sample is not lost.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st          <= '0;
         relative    <= '0;
         velocity    <= '0;
         error_count <= '0;
      end else begin
         st.initialised <= init_n;
         st.prev_raw    <= update ? raw : st.prev_raw;
         st.rev         <= rev_n;
         st.absolute    <= abs_n;
         st.offset      <= zero ? abs_n : st.offset;
         relative       <= zero ? '0 : update ? abs_n - st.offset : relative;
         st.snapshot    <= tick ? abs_n : st.snapshot;
         velocity       <= !tick ? velocity : init_n ? abs_n - st.snapshot : '0;
         error_count    <= (error && error_count != 16'hFFFF) ? error_count + 16'd1 : error_count;
      end
   end
endmodule

// File: rtl/a1339_angle_unwrapper.sv
// a1339_angle_unwrapper: turns time-multiplexed raw A1339 angles into per-channel multi-turn state
// Inputs:  clock, reset (async, active-high), smp (slave beat), zero_offset
// Outputs: angle_absolute/offset/relative, revolution_counter, angle_velocity (32*N),
//          cycle[N] update strobe, error_count (16*N)
module a1339_angle_unwrapper
   import a1339_angle_unwrapper_pkg::*;
#(
   parameter int NUMBER_OF_SENSORS = 8,
   parameter int CLOCK_SPEED_HZ    = 50_000_000,
   parameter int VELOCITY_RATE_HZ  = 100
) (
   input  logic                           clock,
   input  logic                           reset,
   a1339_angle_unwrapper_if.slave         smp,
   input  logic                           zero_offset,
   output logic [32*NUMBER_OF_SENSORS-1:0] angle_absolute,
   output logic [32*NUMBER_OF_SENSORS-1:0] angle_offset,
   output logic [32*NUMBER_OF_SENSORS-1:0] angle_relative,
   output logic [32*NUMBER_OF_SENSORS-1:0] revolution_counter,
   output logic [32*NUMBER_OF_SENSORS-1:0] angle_velocity,
   output logic [NUMBER_OF_SENSORS-1:0]    cycle,
   output logic [16*NUMBER_OF_SENSORS-1:0] error_count
);
   localparam int CH_W   = NUMBER_OF_SENSORS > 1 ? $clog2(NUMBER_OF_SENSORS) : 1;
   localparam int PERIOD = CLOCK_SPEED_HZ / VELOCITY_RATE_HZ;
   localparam int PS_W   = PERIOD > 1 ? $clog2(PERIOD) : 1;

   logic                         s1_valid;
   logic                         s1_error;
   logic [CH_W-1:0]              s1_channel;
   angle_raw_t                   s1_angle;
   logic [PS_W-1:0]              prescale;
   logic                         tick;
   logic [NUMBER_OF_SENSORS-1:0] update;
   logic [NUMBER_OF_SENSORS-1:0] reject;

   assign tick = prescale == PS_W'(PERIOD - 1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_error   <= 1'b0;
         s1_channel <= '0;
         s1_angle   <= '0;
         prescale   <= '0;
         cycle      <= '0;
      end else begin
         s1_valid   <= smp.sample_valid;
         s1_error   <= smp.sample_error;
         s1_channel <= smp.sample_channel;
         s1_angle   <= smp.sample_angle;
         prescale   <= tick ? '0 : prescale + 1'b1;
         cycle      <= update;
      end
   end

   // Out-of-range channel indices match no decode bit and are silently dropped.
   for (genvar i = 0; i < NUMBER_OF_SENSORS; i++) begin : g_ch
      assign update[i] = s1_valid & ~s1_error & (s1_channel == CH_W'(i));
      assign reject[i] = s1_valid & s1_error & (s1_channel == CH_W'(i));
      a1339_angle_unwrapper_channel u_ch (
         .clock       (clock),
         .reset       (reset),
         .update      (update[i]),
         .error       (reject[i]),
         .zero        (zero_offset),
         .tick        (tick),
         .raw         (s1_angle),
         .absolute    (angle_absolute[32*i +: 32]),
         .offset      (angle_offset[32*i +: 32]),
         .relative    (angle_relative[32*i +: 32]),
         .revolution  (revolution_counter[32*i +: 32]),
         .velocity    (angle_velocity[32*i +: 32]),
         .error_count (error_count[16*i +: 16])
      );
   end
endmodule

// File: tb/tb_a1339_angle_unwrapper.sv
// tb_a1339_angle_unwrapper: directed and randomized check of the angle unwrapper against a behavioural model
module tb_a1339_angle_unwrapper;
   localparam int N = 6;
   localparam int PERIOD = 1000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic zero_offset = 1'b0;
   logic [32*N-1:0] angle_absolute, angle_offset, angle_relative, revolution_counter, angle_velocity;
   logic [N-1:0] cycle;
   logic [16*N-1:0] error_count;
   int checks = 0;
   int failures = 0;

   a1339_angle_unwrapper_if #(.CH_W(3)) smp ();

   a1339_angle_unwrapper #(
      .NUMBER_OF_SENSORS(N),
      .CLOCK_SPEED_HZ(100_000),
      .VELOCITY_RATE_HZ(100)
   ) dut (
      .clock(clock),
      .reset(reset),
      .smp(smp),
      .zero_offset(zero_offset),
      .angle_absolute(angle_absolute),
      .angle_offset(angle_offset),
      .angle_relative(angle_relative),
      .revolution_counter(revolution_counter),
      .angle_velocity(angle_velocity),
      .cycle(cycle),
      .error_count(error_count)
   );

   always #5 clock = ~clock;

   int m_init[N], m_prev[N], m_rev[N], m_abs[N], m_off[N], m_rel[N], m_vel[N], m_snap[N], m_err[N];
   logic [N-1:0] m_cyc;
   int m_pc;
   bit p_valid, p_err;
   int p_ch, p_raw;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, $signed(act), $signed(exp));
      end
   endtask

   // Reference model: state after each active edge, from the unwrap rules in plain integer arithmetic.
   always @(posedge clock) begin
      int d;
      if (reset) begin
         for (int c = 0; c < N; c++) begin
            m_init[c] = 0; m_prev[c] = 0; m_rev[c] = 0; m_abs[c] = 0; m_off[c] = 0;
            m_rel[c] = 0; m_vel[c] = 0; m_snap[c] = 0; m_err[c] = 0;
         end
         m_cyc = '0;
         m_pc = 0;
         p_valid = 0;
      end else begin
         m_cyc = '0;
         if (p_valid && p_ch < N) begin
            if (p_err) begin
               if (m_err[p_ch] < 65535) m_err[p_ch]++;
            end else begin
               if (m_init[p_ch] != 0) begin
                  d = p_raw - m_prev[p_ch];
                  if (d > 2047) m_rev[p_ch]--;
                  else if (d < -2048) m_rev[p_ch]++;
               end
               m_init[p_ch] = 1;
               m_prev[p_ch] = p_raw;
               m_abs[p_ch] = m_rev[p_ch] * 4096 + p_raw;
               m_rel[p_ch] = m_abs[p_ch] - m_off[p_ch];
               m_cyc[p_ch] = 1'b1;
            end
         end
         if (zero_offset)
            for (int c = 0; c < N; c++) begin
               m_off[c] = m_abs[c];
               m_rel[c] = 0;
            end
         if (m_pc == PERIOD - 1) begin
            for (int c = 0; c < N; c++) begin
               m_vel[c] = m_init[c] != 0 ? m_abs[c] - m_snap[c] : 0;
               m_snap[c] = m_abs[c];
            end
            m_pc = 0;
         end else m_pc++;
         p_valid = smp.sample_valid;
         p_err = smp.sample_error;
         p_ch = int'(smp.sample_channel);
         p_raw = int'(smp.sample_angle);
      end
      #1;
      chk("cycle", 32'(cycle), 32'(m_cyc));
      for (int c = 0; c < N; c++) begin
         chk($sformatf("abs%0d", c), angle_absolute[32*c +: 32], m_abs[c]);
         chk($sformatf("off%0d", c), angle_offset[32*c +: 32], m_off[c]);
         chk($sformatf("rel%0d", c), angle_relative[32*c +: 32], m_rel[c]);
         chk($sformatf("rev%0d", c), revolution_counter[32*c +: 32], m_rev[c]);
         chk($sformatf("vel%0d", c), angle_velocity[32*c +: 32], m_vel[c]);
         chk($sformatf("err%0d", c), 32'(error_count[16*c +: 16]), m_err[c]);
      end
   end

   task automatic send(input int ch, input int raw, input bit err = 1'b0);
      smp.sample_valid = 1'b1;
      smp.sample_channel = 3'(ch);
      smp.sample_angle = 12'(raw);
      smp.sample_error = err;
      @(negedge clock);
      smp.sample_valid = 1'b0;
      smp.sample_error = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      smp.sample_valid = 1'b0;
      smp.sample_channel = '0;
      smp.sample_angle = '0;
      smp.sample_error = 1'b0;
      idle(3);
      reset = 1'b0;
      chk("rst_abs0", angle_absolute[31:0], 0);
      chk("rst_cycle", 32'(cycle), 0);
      // ch0: straight increments, strobe two clocks after each sample
      send(0, 100);
      send(0, 200);
      chk("c0_abs_100", angle_absolute[31:0], 100);
      chk("c0_cyc_a", 32'(cycle), 1);
      idle(1);
      chk("c0_abs_200", angle_absolute[31:0], 200);
      chk("c0_cyc_b", 32'(cycle), 1);
      idle(1);
      chk("c0_rev", revolution_counter[31:0], 0);
      chk("c0_cyc_off", 32'(cycle), 0);
      // ch1: forward wrap then backward wrap
      send(1, 4000);
      send(1, 50);
      idle(1);
      chk("c1_abs_fwd", angle_absolute[63:32], 4146);
      chk("c1_rev_fwd", revolution_counter[63:32], 1);
      send(1, 4090);
      idle(1);
      chk("c1_abs_back", angle_absolute[63:32], 4090);
      chk("c1_rev_back", revolution_counter[63:32], 0);
      // ch2: +2047 and -2048 do not wrap, +2048 does
      send(2, 0);
      send(2, 2047);
      idle(1);
      chk("c2_abs_2047", angle_absolute[95:64], 2047);
      send(2, 0);
      send(2, 2048);
      idle(1);
      chk("c2_abs_m2048", angle_absolute[95:64], -2048);
      chk("c2_rev_m1", revolution_counter[95:64], -1);
      send(2, 0);
      idle(1);
      chk("c2_abs_m4096", angle_absolute[95:64], -4096);
      // ch3: zero offset capture, then relative motion, then zero coinciding with an update
      send(3, 4000);
      send(3, 50);
      idle(1);
      zero_offset = 1'b1;
      idle(1);
      zero_offset = 1'b0;
      chk("c3_off", angle_offset[127:96], 4146);
      chk("c3_rel0", angle_relative[127:96], 0);
      send(3, 146);
      idle(1);
      chk("c3_abs", angle_absolute[127:96], 4242);
      chk("c3_rel", angle_relative[127:96], 96);
      send(3, 200);
      zero_offset = 1'b1;
      idle(1);
      zero_offset = 1'b0;
      chk("c3_off_coinc", angle_offset[127:96], 4296);
      chk("c3_rel_coinc", angle_relative[127:96], 0);
      chk("c3_cyc_coinc", 32'(cycle), 8);
      // ch4: rejected samples and an out-of-range channel
      send(4, 500);
      idle(1);
      send(4, 7, 1'b1);
      send(7, 123);
      send(4, 9, 1'b1);
      send(4, 11, 1'b1);
      idle(2);
      chk("c4_errcnt", 32'(error_count[79:64]), 3);
      chk("c4_abs_kept", angle_absolute[159:128], 500);
      // reset with a sample in stage 1; the next sample must be treated as the first
      send(4, 1000);
      reset = 1'b1;
      idle(1);
      chk("rst_mid_abs4", angle_absolute[159:128], 0);
      chk("rst_mid_err4", 32'(error_count[79:64]), 0);
      chk("rst_mid_rev1", revolution_counter[63:32], 0);
      reset = 1'b0;
      send(4, 4000);
      idle(1);
      chk("c4_first_abs", angle_absolute[159:128], 4000);
      chk("c4_first_rev", revolution_counter[159:128], 0);
      // ch5: velocity over the first period, then a still period
      send(5, 0);
      send(5, 300);
      idle(1);
      chk("c5_abs", angle_absolute[191:160], 300);
      idle(1000);
      chk("c5_vel_300", angle_velocity[191:160], 300);
      idle(1000);
      chk("c5_vel_0", angle_velocity[191:160], 0);
      // randomized traffic on all channels including out-of-range ones
      repeat (3000) begin
         zero_offset = $urandom_range(0, 59) == 0;
         if ($urandom_range(0, 15) < 11)
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)), $urandom_range(0, 9) == 0);
         else
            idle(1);
      end
      zero_offset = 1'b0;
      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
